// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared widths, iteration count and FSM encoding for seq_mul_unit (MUL_RADIX4_EN selects radix-4)
package mul_pkg;

    localparam int OP_W   = 32;
    localparam int PROD_W = 64;

`ifdef MUL_RADIX4_EN
    localparam int BITS_PER_ITER = 2;
`else
    localparam int BITS_PER_ITER = 1;
`endif

    // One BUSY cycle per retired group of multiplier bits.
    localparam int N_ITER = OP_W / BITS_PER_ITER;
    localparam int CNT_W  = $clog2(N_ITER);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(N_ITER - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/mul_step.sv
// rtl/mul_step.sv - one shift-add step: partial-product select, add into upper half, shift right (MUL_RADIX4_EN: two bits/step)
module mul_step
    import mul_pkg::*;
(
    input  logic [PROD_W-1:0]        acc,
    input  logic [OP_W-1:0]          mcand,
`ifdef MUL_RADIX4_EN
    input  logic [OP_W+1:0]          mcand3,
`endif
    input  logic [BITS_PER_ITER-1:0] mplier_bits,
    output logic [PROD_W-1:0]        acc_next
);

`ifdef MUL_RADIX4_EN
    // Upper half stays below A, so upper + 3A always fits in 34 bits.
    logic [OP_W+1:0] pp;
    logic [OP_W+1:0] sum;

    // Select 0/A/2A/3A, add into the upper half, then shift the whole accumulator right by two.
    always_comb begin
        pp = '0;
        case (mplier_bits)
            2'd0:    pp = '0;
            2'd1:    pp = {2'b00, mcand};
            2'd2:    pp = {1'b0, mcand, 1'b0};
            default: pp = mcand3;
        endcase
        sum      = {2'b00, acc[PROD_W-1:OP_W]} + pp;
        acc_next = PROD_W'({sum, acc[OP_W-1:0]} >> BITS_PER_ITER);
    end
`else
    logic [OP_W-1:0] pp;
    logic [OP_W:0]   sum;

    // Add A into the upper half when the multiplier bit is set, then shift right by one.
    always_comb begin
        pp       = mplier_bits[0] ? mcand : '0;
        sum      = {1'b0, acc[PROD_W-1:OP_W]} + {1'b0, pp};
        acc_next = PROD_W'({sum, acc[OP_W-1:0]} >> BITS_PER_ITER);
    end
`endif

endmodule

// File: rtl/seq_mul_unit.sv
// rtl/seq_mul_unit.sv - sequential unsigned 32x32 multiplier with IDLE/BUSY/DONE handshake (MUL_RADIX4_EN halves BUSY time)
module seq_mul_unit
    import mul_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              mul,
    input  logic [0:OP_W-1]   a,
    input  logic [0:OP_W-1]   b,
    output logic              done,
    output logic [0:PROD_W-1] result
);

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [OP_W-1:0]   a_q, a_d;
    logic [OP_W-1:0]   b_q, b_d;
    logic [PROD_W-1:0] acc_q, acc_d;
    logic [PROD_W-1:0] res_q, res_d;
    logic [PROD_W-1:0] step_acc;
    logic [OP_W-1:0]   a_in, b_in;
`ifdef MUL_RADIX4_EN
    logic [OP_W+1:0]   a3_q, a3_d;
`endif

    // Ports are MSB-at-index-0; internal vectors use descending ranges with the same bit weights.
    assign a_in   = a;
    assign b_in   = b;
    assign done   = (state_q == ST_DONE);
    assign result = res_q;

    mul_step u_step (
        .acc         (acc_q),
        .mcand       (a_q),
`ifdef MUL_RADIX4_EN
        .mcand3      (a3_q),
`endif
        .mplier_bits (b_q[BITS_PER_ITER-1:0]),
        .acc_next    (step_acc)
    );

    // Next-state logic: load on request, step while mul stays high, publish the product on the last step.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        res_d   = res_q;
`ifdef MUL_RADIX4_EN
        a3_d    = a3_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (mul) begin
                    a_d     = a_in;
                    b_d     = b_in;
                    acc_d   = '0;
                    cnt_d   = '0;
`ifdef MUL_RADIX4_EN
                    a3_d    = {2'b00, a_in} + {1'b0, a_in, 1'b0};
`endif
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (!mul) begin
                    // Abort: the published result is deliberately left untouched.
                    state_d = ST_IDLE;
                end else begin
                    acc_d = step_acc;
                    b_d   = b_q >> BITS_PER_ITER;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_ITER) begin
                        res_d   = step_acc;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            res_q   <= '0;
`ifdef MUL_RADIX4_EN
            a3_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
`ifdef MUL_RADIX4_EN
            a3_q    <= a3_d;
`endif
        end
    end

endmodule

// File: tb/tb_seq_mul_unit.sv
// tb/tb_seq_mul_unit.sv - self-checking bench for seq_mul_unit with a cycle-level reference model
module tb_seq_mul_unit;

`ifdef MUL_RADIX4_EN
    localparam int LAT = 18;
`else
    localparam int LAT = 34;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        mul;
    logic [31:0] a;
    logic [31:0] b;
    logic        done;
    logic [63:0] result;

    int n_total = 0;
    int n_pass  = 0;
    bit cmp_en  = 1'b0;

    // Reference model: an operation is "active" with an age counted from its request cycle (age 1).
    bit          m_active = 1'b0;
    int          m_age    = 0;
    logic [63:0] m_prod   = '0;
    logic [63:0] m_result = '0;
    logic        exp_done;

    always #5 clk = ~clk;

    seq_mul_unit dut (
        .clk    (clk),
        .reset  (reset),
        .mul    (mul),
        .a      (a),
        .b      (b),
        .done   (done),
        .result (result)
    );

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_active = 1'b0;
            m_age    = 0;
            m_result = '0;
        end else if (!m_active) begin
            if (mul) begin
                m_active = 1'b1;
                m_age    = 2;
                m_prod   = 64'(a) * 64'(b);
            end
        end else if (m_age == LAT) begin
            m_active = 1'b0;
        end else if (!mul) begin
            m_active = 1'b0;
        end else begin
            m_age = m_age + 1;
            if (m_age == LAT) m_result = m_prod;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            exp_done = m_active && (m_age == LAT);
            n_total++;
            if (done === exp_done && result === m_result) n_pass++;
            else $display("FAIL cycle_cmp t=%0t: got done=%b result=%h, expected done=%b result=%h",
                          $time, done, result, exp_done, m_result);
        end
    end

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic drive(input logic [31:0] x, input logic [31:0] y);
        @(posedge clk);
        #1;
        mul = 1'b1;
        a   = x;
        b   = y;
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        mul = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic wait_done(input int start, output int cyc, output logic [63:0] r);
        cyc = -1;
        r   = 'x;
        for (int c = start; c <= LAT + 10; c++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                cyc = c;
                r   = result;
                break;
            end
        end
    endtask

    function automatic logic [31:0] pick();
        int sel;
        sel = $urandom_range(0, 7);
        if (sel == 0) return 32'h0;
        if (sel == 1) return 32'hFFFF_FFFF;
        return 32'($urandom);
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int          cyc;
        logic [63:0] r;
        bit          seen;

        reset = 1'b1;
        mul   = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(posedge clk);
        #1;
        check64("reset_result", result, 64'h0);
        check_int("reset_done", int'(done), 0);
        reset  = 1'b0;
        cmp_en = 1'b1;

        drive(32'd3, 32'd5);
        wait_done(1, cyc, r);
        check_int("basic_cycle", cyc, LAT);
        check64("basic_result", r, 64'h0000_0000_0000_000F);
        check64("basic_model", m_result, 64'h0000_0000_0000_000F);
        idle();

        drive(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(1, cyc, r);
        check_int("max_cycle", cyc, LAT);
        check64("max_result", r, 64'hFFFF_FFFE_0000_0001);
        idle();

        drive(32'h0001_0000, 32'h0001_0000);
        wait_done(1, cyc, r);
        check_int("b2b_first_cycle", cyc, LAT);
        check64("b2b_first_result", r, 64'h0000_0001_0000_0000);
        drive(32'd7, 32'd6);
        wait_done(1, cyc, r);
        check_int("b2b_second_cycle", cyc + LAT, 2 * LAT);
        check64("b2b_second_result", r, 64'h0000_0000_0000_002A);
        idle();

        drive(32'h0000_DEAD, 32'h0000_BEEF);
        repeat (9) @(posedge clk);
        #1;
        mul  = 1'b0;
        seen = 1'b0;
        repeat (LAT + 6) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1'b1;
        end
        check_int("abort_no_done", int'(seen), 0);
        check64("abort_result_kept", result, 64'h0000_0000_0000_002A);
        drive(32'd9, 32'd9);
        wait_done(1, cyc, r);
        check_int("after_abort_cycle", cyc, LAT);
        check64("after_abort_result", r, 64'h0000_0000_0000_0051);
        idle();

        drive(32'h55, 32'h66);
        repeat (19) @(posedge clk);
        #2;
        reset = 1'b1;
        mul   = 1'b0;
        #1;
        check_int("async_reset_done", int'(done), 0);
        check64("async_reset_result", result, 64'h0);
        #1;
        reset = 1'b0;
        drive(32'd2, 32'd2);
        wait_done(1, cyc, r);
        check_int("after_reset_cycle", cyc, LAT);
        check64("after_reset_result", r, 64'h4);
        idle();

        drive(32'h1234, 32'h10);
        @(posedge clk);
        #1;
        a = 32'hFFFF_FFFF;
        b = 32'hFFFF_FFFF;
        wait_done(2, cyc, r);
        check_int("opchange_cycle", cyc, LAT);
        check64("opchange_result", r, 64'h0000_0000_0001_2340);
        idle();

        for (int i = 0; i < 2500; i++) begin
            @(posedge clk);
            #1;
            mul = ($urandom_range(0, 99) != 0);
            a   = pick();
            b   = pick();
        end
        @(posedge clk);
        #1;
        mul = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        cmp_en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/seq_mul_unit.md
SEQ_MUL_UNIT -- requirements
Module: seq_mul_unit

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1, asynchronous, active-high, clears all state immediately.
REQ-003 SHALL have port mul, input, 1, request from the execute stage, held high for as long as the multiply instruction occupies EX.
REQ-004 SHALL have ports a and b, input, 32 each, unsigned operands, bit 0 = MSB.
REQ-005 SHALL have port done, output, 1, result-valid strobe; the execute stage stalls while mul & ~done.
REQ-006 SHALL have port result, output, 64, unsigned product, bit 0 = MSB; EX consumes the low word result[32:63].

Function
REQ-007 SHALL implement FSM states IDLE, BUSY, DONE.
- IDLE: mul=1 at an edge -> load a and b, clear the accumulator and iteration counter, go to BUSY.
- IDLE: mul=0 -> stay in IDLE.
REQ-008 SHALL, in BUSY, retire one multiplier bit per cycle (radix-2 shift-add, LSB first) into a 64-bit accumulator.
- After N_ITER=32 BUSY cycles, go to DONE.
REQ-009 SHALL assert done=1 only in DONE, for exactly one cycle, then go unconditionally to IDLE.
REQ-010 SHALL set latency so that, counting the first mul-high cycle in IDLE as cycle 1, done=1 in cycle 34 with result valid in the same cycle.
REQ-011 SHALL hold result stable from DONE until the next operand load; done is 0 in IDLE and BUSY.
REQ-012 SHALL treat mul still high in the cycle after DONE (IDLE) as a new request, so back-to-back multiplies each take a full 34 cycles.
REQ-013 SHALL ignore changes on a and b after the load edge.
REQ-014 SHALL abort when mul=0 in BUSY: go to IDLE, keep done=0, leave result at its previous value.
REQ-015 SHALL compute an exact 64-bit product with no overflow, including 0xFFFFFFFF x 0xFFFFFFFF.

Reset
REQ-016 SHALL, while reset=1, force state=IDLE, done=0, result=0, accumulator=0, counter=0 and operand registers=0, regardless of clk.
REQ-017 SHALL discard any in-flight operation on reset; after release, a new request takes the full latency.

Configuration
REQ-018 SHALL support macro MUL_RADIX4_EN.
- Defined: retire two multiplier bits per BUSY cycle, selecting 0, A, 2A or 3A (3A precomputed at load); N_ITER=16; done in cycle 18.
- Undefined: radix-2 behaviour and 34-cycle latency per REQ-008/REQ-010.
- Products SHALL be identical in both builds.

Structure
REQ-019 SHALL place the FSM state encoding, N_ITER (derived from MUL_RADIX4_EN) and the operand/product width constants (32/64) in shared package mul_pkg.
REQ-020 SHALL split the combinational accumulate-and-shift datapath (partial-product select, 64-bit add, shift) into one sub-module mul_step; seq_mul_unit holds the FSM, counter and registers.

Verification
REQ-021 SHALL cover basic: a=3, b=5, mul held high -> done=1 in cycle 34 (18 with MUL_RADIX4_EN), result=0x000000000000000F, done=0 in all other cycles.
REQ-022 SHALL cover max operands: a=b=0xFFFFFFFF -> result=0xFFFFFFFE00000001.
REQ-023 SHALL cover back-to-back: 0x10000 x 0x10000, then 7 x 6 with mul kept high -> done at cycle 34 with result=0x0000000100000000, then done at cycle 68 with result=0x2A.
REQ-024 SHALL cover abort: mul dropped in cycle 10 -> IDLE, done never asserts, prior result unchanged; a new request then completes at full latency.
REQ-025 SHALL cover reset mid-operation: reset pulsed asynchronously in cycle 20 -> done=0 and result=0 immediately; 2 x 2 requested after release -> result=4 after full latency.
REQ-026 SHALL cover operand change: a and b changed in cycle 2 -> result reflects the operands captured in cycle 1.
